// File: rtl/buf_addr_pool.sv
// Free-buffer address pool: fills itself with NUM_BUFS buffer addresses after reset, then issues and recycles them in FIFO order.
// Optional return-address validation is enabled by defining BUF_ADDR_POOL_CHECK_EN.
module buf_addr_pool #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    BUF_SIZE   = 2048,
  parameter int                    NUM_BUFS   = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [ADDR_WIDTH-1:0]         m_tdata,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  input  logic [ADDR_WIDTH-1:0]         r_tdata,
  input  logic                          r_tvalid,
  output logic                          r_tready,
  output logic [$clog2(NUM_BUFS):0]     free_count,
  output logic                          init_done,
  output logic                          err_bad_return
);

  localparam int                PTR_W    = $clog2(NUM_BUFS);
  localparam int                CNT_W    = PTR_W + 1;
  localparam int                SHIFT    = $clog2(BUF_SIZE);
  localparam logic [CNT_W-1:0]  FULL     = CNT_W'(NUM_BUFS);
  localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(NUM_BUFS - 1);

  typedef enum logic {INIT, RUN} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   mem [NUM_BUFS];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr, fill_idx;
  logic [CNT_W-1:0]        count;
  logic                    fill, pop, ret_hs, ret_ok, push, mem_we;
  logic [ADDR_WIDTH-1:0]   mem_wdata;

  // Buffer idx address; BUF_SIZE is a power of two so the multiply is a shift.
  function automatic logic [ADDR_WIDTH-1:0] fill_addr(input logic [PTR_W-1:0] idx);
    return BASE_ADDR + (ADDR_WIDTH'(idx) << SHIFT);
  endfunction

`ifdef BUF_ADDR_POOL_CHECK_EN
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(NUM_BUFS) << SHIFT;

  // Span compare is one bit wider so a pool reaching the top of the address space still works.
  function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return (addr >= BASE_ADDR) && ((ADDR_WIDTH + 1)'(off) < SPAN) && (off[SHIFT-1:0] == '0);
  endfunction

  logic err_q;

  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= ret_hs & ~ret_ok;
  end

  assign ret_ok         = addr_ok(r_tdata);
  assign err_bad_return = err_q;
`else
  assign ret_ok         = 1'b1;
  assign err_bad_return = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= INIT;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    fill       = 1'b0;
    m_tvalid   = 1'b0;
    r_tready   = 1'b0;
    m_tdata    = '0;
    case (state)
      INIT: begin
        fill = 1'b1;
        if (fill_idx == LAST_IDX) next_state = RUN;
      end
      RUN: begin
        m_tvalid = (count != '0);
        r_tready = (count < FULL);
        if (count != '0) m_tdata = mem[rd_ptr];
      end
      default: next_state = INIT;
    endcase
  end

  assign pop        = m_tvalid & m_tready;
  assign ret_hs     = r_tvalid & r_tready;
  assign push       = ret_hs & ret_ok;
  assign mem_we     = fill | push;
  assign mem_wdata  = fill ? fill_addr(fill_idx) : r_tdata;
  assign free_count = count;
  assign init_done  = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fill_idx <= '0;
      count    <= '0;
    end else begin
      if (fill)   fill_idx <= fill_idx + PTR_W'(1);
      if (mem_we) wr_ptr   <= wr_ptr + PTR_W'(1);
      if (pop)    rd_ptr   <= rd_ptr + PTR_W'(1);
      case ({mem_we, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr] <= mem_wdata;
  end

endmodule

// File: tb/tb_buf_addr_pool.sv
// Randomized scoreboard bench for buf_addr_pool (NUM_BUFS=4, BASE_ADDR=0x1000_0000, BUF_SIZE=2048).
module tb_buf_addr_pool;

  localparam int          N    = 4;
  localparam int          BUF  = 2048;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] r_tdata;
  logic        r_tvalid;
  logic        r_tready;
  logic [2:0]  free_count;
  logic        init_done;
  logic        err_bad_return;

  int checks   = 0;
  int failures = 0;

  buf_addr_pool #(
    .ADDR_WIDTH(32),
    .BASE_ADDR (BASE),
    .BUF_SIZE  (BUF),
    .NUM_BUFS  (N)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .r_tdata       (r_tdata),
    .r_tvalid      (r_tvalid),
    .r_tready      (r_tready),
    .free_count    (free_count),
    .init_done     (init_done),
    .err_bad_return(err_bad_return)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  function automatic bit addr_good(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + longint'(N) * BUF) && ((la - lb) % BUF == 0);
  endfunction

  function automatic logic [31:0] rand_ret();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7)       return BASE + 32'($urandom_range(0, N - 1) * BUF);
    else if (r == 7) return BASE + 32'($urandom_range(0, N - 1) * BUF) + 32'd4;
    else if (r == 8) return BASE + 32'(N * BUF);
    else             return BASE - 32'(BUF);
  endfunction

  // Reference model: pool contents as a FIFO of addresses, plus INIT progress.
  logic [31:0] q[$];
  bit          run       = 0;
  int          fill      = 0;
  bit          exp_err   = 0;
  bit          rst_state = 1;

  initial begin
    bit exp_v, do_pop, do_ret;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_v = run && (q.size() > 0);
      chk("init_done", 32'(init_done), 32'(run));
      chk("free_count", 32'(free_count), 32'(q.size()));
      chk("m_tvalid", 32'(m_tvalid), 32'(exp_v));
      chk("r_tready", 32'(r_tready), 32'(run && (q.size() < N)));
      chk("err_bad_return", 32'(err_bad_return), 32'(exp_err));
      if (exp_v)                 chk("m_tdata", m_tdata, q[0]);
      else if (run || rst_state) chk("m_tdata_idle", m_tdata, 32'h0);

      exp_err = 0;
      if (reset) begin
        q.delete();
        run       = 0;
        fill      = 0;
        rst_state = 1;
      end else if (!run) begin
        q.push_back(BASE + 32'(fill * BUF));
        fill++;
        rst_state = 0;
        if (fill == N) run = 1;
      end else begin
        do_pop = m_tready && (q.size() > 0);
        do_ret = r_tvalid && (q.size() < N);
        if (do_pop) void'(q.pop_front());
        if (do_ret) begin
`ifdef BUF_ADDR_POOL_CHECK_EN
          if (!addr_good(r_tdata)) exp_err = 1;
          else                     q.push_back(r_tdata);
`else
          q.push_back(r_tdata);
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cycles(input int n, input int p_pop, input int p_ret);
    for (int i = 0; i < n; i++) begin
      m_tready = ($urandom_range(0, 99) < p_pop);
      r_tvalid = ($urandom_range(0, 99) < p_ret);
      r_tdata  = rand_ret();
      step();
    end
  endtask

  initial begin
    reset    = 1'b1;
    m_tready = 1'b0;
    r_tvalid = 1'b0;
    r_tdata  = '0;
    repeat (3) step();
    reset = 1'b0;

    // Fill, then drain back-to-back until empty.
    m_tready = 1'b1;
    repeat (10) step();

    // Single return into empty pool, held briefly, then taken.
    m_tready = 1'b0;
    r_tvalid = 1'b1;
    r_tdata  = BASE + 32'h800;
    step();
    r_tvalid = 1'b0;
    repeat (3) step();
    m_tready = 1'b1;
    step();

    // Directed bad returns (stored in the default build, rejected with checking).
    m_tready = 1'b0;
    r_tvalid = 1'b1;
    r_tdata  = BASE + 32'h804;
    step();
    r_tdata  = BASE + 32'h2000;
    step();
    r_tvalid = 1'b0;
    m_tready = 1'b1;
    repeat (4) step();

    rand_cycles(150, 50, 50);
    rand_cycles(100, 10, 90);
    rand_cycles(100, 90, 20);
    rand_cycles(100, 0, 0);

    // Reset mid-operation after a couple of pops.
    m_tready = 1'b1;
    r_tvalid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_tready = 1'b0;
    repeat (6) step();
    m_tready = 1'b1;
    repeat (3) step();

    rand_cycles(300, 60, 60);
    rand_cycles(100, 100, 100);

    r_tvalid = 1'b0;
    m_tready = 1'b0;
    step();
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/buf_addr_pool.md
# buf_addr_pool

Free-buffer address pool that feeds the address AXI-Stream input of the packet-to-memory datamover. After reset it fills itself with NUM_BUFS buffer addresses (BASE_ADDR + i·BUF_SIZE), hands them out one per stream beat, and takes back addresses that software or the packet consumer returns once a buffer is released. When the pool is empty `m_tvalid` drops, which stalls the datamover's packet input.

## Interface
- `ADDR_WIDTH`, 32: width of address words; must match the datamover address input.
- `BASE_ADDR`, 32'h0000_0000: address of buffer 0; aligned to BUF_SIZE.
- `BUF_SIZE`, 2048: bytes per buffer; power of two, ≥ 1600.
- `NUM_BUFS`, 64: pool depth; power of two, 2..1024.
- `clk`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_tdata`  out  ADDR_WIDTH  issued buffer address.
- `m_tvalid`  out  1  address available.
- `m_tready`  in  1  consumer (datamover) accepts address.
- `r_tdata`  in  ADDR_WIDTH  returned buffer address.
- `r_tvalid`  in  1  return valid.
- `r_tready`  out  1  pool accepts return.
- `free_count`  out  $clog2(NUM_BUFS)+1  addresses currently held.
- `init_done`  out  1  fill complete, pool in RUN.
- `err_bad_return`  out  1  one-cycle pulse on rejected return (see Configuration).

## Operation
- Storage: NUM_BUFS × ADDR_WIDTH register array, circular; `wr_ptr`, `rd_ptr` ($clog2(NUM_BUFS) bits, natural wrap), `count` (one extra bit).
- States: INIT, RUN. Reset → INIT with ptrs=0, count=0, fill index=0.
- INIT: each cycle write BASE_ADDR + idx·BUF_SIZE at wr_ptr, wr_ptr++, count++, idx++. After write of idx = NUM_BUFS−1 → RUN. `m_tvalid`=0, `r_tready`=0 throughout INIT.
- RUN: `m_tvalid` = (count ≠ 0); `m_tdata` = mem[rd_ptr] when count ≠ 0, else 0. Pop on `m_tvalid & m_tready`: rd_ptr++, count−−.
- RUN: `r_tready` = (count < NUM_BUFS). Push on `r_tvalid & r_tready`: mem[wr_ptr] ← r_tdata, wr_ptr++, count++.
- Simultaneous pop and push: both pointers advance, count unchanged. Push cannot occur when full (r_tready low); pop cannot occur when empty.
- Strict FIFO order: addresses issued in fill order, then in return order.
- Address arithmetic in ADDR_WIDTH bits; idx·BUF_SIZE computed as shift (BUF_SIZE power of two). BASE_ADDR + NUM_BUFS·BUF_SIZE must not exceed 2^ADDR_WIDTH (not checked).
- No duplicate detection: returning an address twice places it twice.
- `free_count` = count; `init_done` = (state == RUN).
- Reset mid-operation: all state discarded, INIT restarts, previously issued addresses forgotten; pool refills to NUM_BUFS.

## Timing
- Reset values: `m_tvalid`=0, `m_tdata`=0, `r_tready`=0, `free_count`=0, `init_done`=0, `err_bad_return`=0.
- First clock edge with reset low performs write idx 0; INIT lasts exactly NUM_BUFS cycles; `init_done` and `m_tvalid` rise in the cycle after the last write, `m_tdata`=BASE_ADDR.
- `m_tdata` stable while `m_tvalid & !m_tready` (rd_ptr moves only on pop); `m_tvalid` never drops without a pop.
- Return into empty pool: handshake at edge E → `m_tvalid`=1 with that address in the cycle after E (1-cycle latency).
- `free_count` reflects edge updates in the following cycle; one address issued per cycle maximum.
- Back-to-back pops every cycle supported; no bubbles.

## Configuration
- `BUF_ADDR_POOL_CHECK_EN` defined: each returned address is checked for BASE_ADDR ≤ addr < BASE_ADDR + NUM_BUFS·BUF_SIZE and (addr − BASE_ADDR) mod BUF_SIZE = 0. Invalid returns still complete the handshake (`r_tready` unchanged) but are not stored; `err_bad_return` pulses high for one cycle after the handshake edge; count unchanged.
- Not defined: every accepted return is stored; `err_bad_return` tied 0.

## Test plan
- NUM_BUFS=4, BASE_ADDR=0x1000_0000, BUF_SIZE=2048, release reset, `m_tready`=1 after `init_done` → `init_done` after 4 cycles, issued 0x1000_0000, 0x1000_0800, 0x1000_1000, 0x1000_1800 on consecutive cycles, then `m_tvalid`=0, `free_count`=0.
- Empty pool, return 0x1000_0800 → next cycle `m_tvalid`=1, `m_tdata`=0x1000_0800, `free_count`=1.
- count=2, pop and return 0x1000_1000 in same cycle → `free_count` stays 2, returned address issued after the remaining one.
- Hold `m_tready`=0 for 5 cycles with `m_tvalid`=1 → `m_tdata` and `free_count` constant; `r_tready`=0 while `free_count`=4.
- With `BUF_ADDR_POOL_CHECK_EN`: return 0x1000_0804, then 0x1000_2000 → two `err_bad_return` pulses, `free_count` unchanged, neither ever issued.
- Pop 2 addresses, assert `reset` one cycle → INIT restarts, `free_count` returns to 4 after 4 cycles, first issued address 0x1000_0000.
